// File: rtl/alu_seq_ctrl.sv
// Sequencer that accepts one ALU request at a time and drives an external combinational ALU.
// It registers the response and holds it until the consumer takes it.
module alu_seq_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [5:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic [12:0]  alu_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_cond,
    output logic         out_err,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       state, state_nxt;
    logic [4:0]   op_q;
    logic [N-1:0] a_q, b_q;
    logic         accept, retire, bad_req;
    logic [3:0]   cond_idx;
    logic         cond_sel;

    // Ops 0..6 use a sparse encoding; ops 7..19 use a contiguous block starting at 001100.
    function automatic logic [5:0] map_ctrl(input logic [4:0] op);
        case (op)
            5'd0:    map_ctrl = 6'b000000;
            5'd1:    map_ctrl = 6'b000001;
            5'd2:    map_ctrl = 6'b000010;
            5'd3:    map_ctrl = 6'b000100;
            5'd4:    map_ctrl = 6'b000101;
            5'd5:    map_ctrl = 6'b000110;
            5'd6:    map_ctrl = 6'b000111;
            default: map_ctrl = (op <= 5'd19) ? ({1'b0, op} + 6'd5) : 6'b000000;
        endcase
    endfunction

    assign accept  = in_valid && (state == IDLE);
    assign retire  = out_ready && (state == DONE);
    // An illegal op or a divide by zero never reaches the ALU.
    assign bad_req = (in_op > 5'd19) || ((in_op == 5'd3) && (in_b == '0));

    assign cond_idx = 4'(op_q - 5'd7);
    assign cond_sel = (op_q >= 5'd7) && alu_flags[cond_idx];

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = 6'b000000;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = bad_req ? DONE : EXEC;
            end
            EXEC: begin
                alu_a       = a_q;
                alu_b       = b_q;
                alu_control = map_ctrl(op_q);
                state_nxt   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            out_result <= '0;
            out_cond   <= 1'b0;
            out_err    <= 1'b0;
        end else if (accept) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
            if (bad_req) begin
                out_result <= '0;
                out_cond   <= 1'b0;
                out_err    <= 1'b1;
            end
        end else if (state == EXEC) begin
            out_result <= alu_result;
            out_cond   <= cond_sel;
            out_err    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              op_count <= '0;
        else if (retire && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table plus hand-written backpressure, reset and saturation sequences.
// The bench plays the ALU: it returns the vector's result only when control and operands match.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_control;
    logic [12:0] alu_flags;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_cond, out_err;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt = '0;

    logic [5:0]  cur_ctrl = '0;
    logic [31:0] cur_a = '0, cur_b = '0, cur_res = '0;
    logic [12:0] cur_flg = '0;

    always #5 clk = ~clk;

    logic alu_match;
    assign alu_match  = (alu_control == cur_ctrl) && (alu_a == cur_a) && (alu_b == cur_b);
    assign alu_result = alu_match ? cur_res : 32'hBAD0_BAD0;
    assign alu_flags  = alu_match ? cur_flg : 13'h0;

    alu_seq_ctrl #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cond(out_cond), .out_err(out_err),
        .op_count(op_count)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic [12:0] flg;
        logic [5:0]  ctrl;
        logic [31:0] eres;
        logic        ecnd, eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One full request/response; early raises out_ready before the accept.
    task automatic txn(input vec_t v, input logic early);
        cur_ctrl = v.ctrl; cur_a = v.a; cur_b = v.b; cur_res = v.res; cur_flg = v.flg;
        @(negedge clk);
        in_op = v.op; in_a = v.a; in_b = v.b; in_valid = 1'b1;
        out_ready = early;
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (!v.eerr) begin
            chk("exec_ctrl", alu_control, v.ctrl);
            chk("exec_a", alu_a, v.a);
            chk("exec_b", alu_b, v.b);
            chk("exec_out_valid", out_valid, 0);
            chk("exec_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("done_out_valid", out_valid, 1);
        chk("done_ctrl", alu_control, 0);
        chk("done_in_ready", in_ready, 0);
        chk("result", out_result, v.eres);
        chk("cond", out_cond, v.ecnd);
        chk("err", out_err, v.eerr);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        chk("op_count", op_count, exp_cnt);
        chk("post_out_valid", out_valid, 0);
    endtask

    initial begin
        vecs.push_back('{op:1,  a:5,  b:7,  res:12, flg:0,       ctrl:6'h01, eres:12, ecnd:0, eerr:0});
        vecs.push_back('{op:1,  a:1,  b:2,  res:3,  flg:13'h1FFF, ctrl:6'h01, eres:3,  ecnd:0, eerr:0});
        vecs.push_back('{op:9,  a:3,  b:9,  res:1,  flg:13'h004, ctrl:6'h0E, eres:1,  ecnd:1, eerr:0});
        vecs.push_back('{op:9,  a:9,  b:3,  res:0,  flg:13'h000, ctrl:6'h0E, eres:0,  ecnd:0, eerr:0});
        vecs.push_back('{op:2,  a:10, b:3,  res:7,  flg:0,       ctrl:6'h02, eres:7,  ecnd:0, eerr:0});
        vecs.push_back('{op:3,  a:10, b:2,  res:5,  flg:0,       ctrl:6'h04, eres:5,  ecnd:0, eerr:0});
        vecs.push_back('{op:4,  a:6,  b:7,  res:42, flg:0,       ctrl:6'h05, eres:42, ecnd:0, eerr:0});
        vecs.push_back('{op:5,  a:32'hFFFF_FFFF, b:32'hF0F0_F0F0, res:32'hF0F0_F0F0, flg:0, ctrl:6'h06, eres:32'hF0F0_F0F0, ecnd:0, eerr:0});
        vecs.push_back('{op:6,  a:32'h8000_0000, b:1, res:32'h8000_0001, flg:0, ctrl:6'h07, eres:32'h8000_0001, ecnd:0, eerr:0});
        vecs.push_back('{op:0,  a:4,  b:4,  res:32'h1234, flg:0, ctrl:6'h00, eres:32'h1234, ecnd:0, eerr:0});
        vecs.push_back('{op:7,  a:4,  b:4,  res:0,  flg:13'h001, ctrl:6'h0C, eres:0, ecnd:1, eerr:0});
        vecs.push_back('{op:12, a:8,  b:2,  res:0,  flg:13'h020, ctrl:6'h11, eres:0, ecnd:1, eerr:0});
        vecs.push_back('{op:13, a:1,  b:1,  res:0,  flg:13'h040, ctrl:6'h12, eres:0, ecnd:1, eerr:0});
        vecs.push_back('{op:19, a:2,  b:3,  res:0,  flg:13'h1000, ctrl:6'h18, eres:0, ecnd:1, eerr:0});
        vecs.push_back('{op:19, a:2,  b:3,  res:0,  flg:13'h0FFF, ctrl:6'h18, eres:0, ecnd:0, eerr:0});
        vecs.push_back('{op:3,  a:10, b:0,  res:99, flg:13'h1FFF, ctrl:6'h04, eres:0, ecnd:0, eerr:1});
        vecs.push_back('{op:25, a:10, b:0,  res:99, flg:13'h1FFF, ctrl:6'h00, eres:0, ecnd:0, eerr:1});
        vecs.push_back('{op:20, a:1,  b:2,  res:99, flg:0,       ctrl:6'h00, eres:0, ecnd:0, eerr:1});
        vecs.push_back('{op:31, a:1,  b:2,  res:99, flg:0,       ctrl:6'h00, eres:0, ecnd:0, eerr:1});

        // Reset values
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_cond", out_cond, 0);
        chk("rst_err", out_err, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_ctrl", alu_control, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) txn(vecs[i], 1'b0);
        txn(vecs[0], 1'b1);

        // Backpressure with a second request waiting
        cur_ctrl = 6'h01; cur_a = 20; cur_b = 22; cur_res = 42; cur_flg = 0;
        @(negedge clk);
        in_op = 5'd1; in_a = 20; in_b = 22; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_exec_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", out_result, 42);
            chk("bp_cond", out_cond, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk("bp_op_count", op_count, exp_cnt);
        chk("bp_idle_out_valid", out_valid, 0);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_ctrl", alu_control, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_exec", alu_control, 6'h01);
        @(negedge clk);
        chk("bp_second_done", out_valid, 1);
        chk("bp_second_result", out_result, 42);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk("bp_second_count", op_count, exp_cnt);

        // Reset in the middle of EXEC
        cur_ctrl = 6'h05; cur_a = 6; cur_b = 7; cur_res = 42;
        @(negedge clk);
        in_op = 5'd4; in_a = 6; in_b = 7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_exec_ctrl", alu_control, 6'h05);
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk("mr_ctrl", alu_control, 0);
        chk("mr_alu_a", alu_a, 0);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_op_count", op_count, 0);
        chk("mr_result", out_result, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_out_valid", out_valid, 0);
        end
        txn(vecs[0], 1'b0);

        // Counter saturation
        @(negedge clk);
        force dut.op_count = 16'hFFFC;
        @(negedge clk);
        release dut.op_count;
        exp_cnt = 16'hFFFC;
        chk("sat_preload", op_count, 16'hFFFC);
        for (int i = 0; i < 5; i++) txn(vecs[i], 1'b0);
        chk("sat_final", op_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
